// File: rtl/data_ram_wait.sv
// Clocked byte-addressed data memory with req/ack handshake, programmable wait states,
// big-endian byte/half/word access and fault responses for illegal requests.
module data_ram_wait #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        signed_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic        fault,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                rw_q;
  logic [1:0]          size_q;
  logic                sl_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [7:0]          mem [2**ADDR_W];

  logic [ADDR_W-1:0]   a0, a1, a2, a3;
  logic [7:0]          m0, m1, m2, m3;
  logic                access;

  function automatic logic is_legal(input logic [1:0] sz, input logic [31:0] ad);
    logic in_range;
    in_range = (ad >> ADDR_W) == 32'd0;
    case (sz)
      2'b00:   return in_range;
      2'b01:   return in_range && !ad[0];
      2'b10:   return in_range && (ad[1:0] == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Big-endian assembly of the load result with optional sign extension.
  function automatic logic [31:0] load_fmt(input logic [1:0] sz, input logic sx,
                                           input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    sb = signed'(b0);
    sh = signed'({b0, b1});
    case (sz)
      2'b00:   return sx ? 32'(sb) : {24'd0, b0};
      2'b01:   return sx ? 32'(sh) : {16'd0, b0, b1};
      default: return {b0, b1, b2, b3};
    endcase
  endfunction

  assign a0     = addr_q;
  assign a1     = addr_q + ADDR_W'(1);
  assign a2     = addr_q + ADDR_W'(2);
  assign a3     = addr_q + ADDR_W'(3);
  assign m0     = mem[a0];
  assign m1     = mem[a1];
  assign m2     = mem[a2];
  assign m3     = mem[a3];
  assign access = (state == WAIT) && (cnt == 4'd0);

  // Request capture: data path only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      rw_q    <= rw;
      size_q  <= size;
      sl_q    <= signed_ld;
      addr_q  <= addr[ADDR_W-1:0];
      wdata_q <= wdata;
    end
  end

  // Memory array is never reset; a reset before the access edge leaves state IDLE,
  // so a pending write is dropped.
  always_ff @(posedge clk) begin
    if (access && rw_q) begin
      case (size_q)
        2'b00: mem[a0] <= wdata_q[7:0];
        2'b01: begin
          mem[a0] <= wdata_q[15:8];
          mem[a1] <= wdata_q[7:0];
        end
        2'b10: begin
          mem[a0] <= wdata_q[31:24];
          mem[a1] <= wdata_q[23:16];
          mem[a2] <= wdata_q[15:8];
          mem[a3] <= wdata_q[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      ack   <= 1'b0;
      fault <= 1'b0;
      rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          ack   <= 1'b0;
          fault <= 1'b0;
          if (req) begin
            busy <= 1'b1;
            if (is_legal(size, addr)) begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES);
            end else begin
              state <= RESP;
              ack   <= 1'b1;
              fault <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RESP;
            ack   <= 1'b1;
            if (!rw_q) rdata <= load_fmt(size_q, sl_q, m0, m1, m2, m3);
          end
        end
        RESP: begin
          ack   <= 1'b0;
          fault <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_wait.sv
// Directed bench for data_ram_wait (ADDR_W=8, WAIT_STATES=2): vector table plus
// hand-written reset-mid-write and held-request sequences.
module tb_data_ram_wait;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic        rw;
  logic [1:0]  size;
  logic        signed_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ack;
  logic        fault;
  logic [31:0] rdata;

  int n_total = 0;
  int n_pass  = 0;

  data_ram_wait #(.ADDR_W(8), .WAIT_STATES(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .rw(rw), .size(size),
    .signed_ld(signed_ld), .addr(addr), .wdata(wdata),
    .busy(busy), .ack(ack), .fault(fault), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        sl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flt;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [1:0] s, logic sl, logic [31:0] a,
                              logic [31:0] w, logic f, logic [31:0] rd);
    vec_t v;
    v.rw = r; v.size = s; v.sl = sl; v.addr = a; v.wdata = w; v.flt = f; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // One transaction: accept at E0, then scramble inputs to prove they were captured.
  task automatic txn(input vec_t v, input int idx);
    int bc, ak;
    logic got, af;
    logic [31:0] ar;
    bc = 0; ak = -1; got = 1'b0; af = 1'b0; ar = 32'd0;
    @(negedge clk);
    rw = v.rw; size = v.size; signed_ld = v.sl; addr = v.addr; wdata = v.wdata; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0; rw = ~v.rw; size = 2'b11; signed_ld = ~v.sl; addr = 32'hFFFF_FFFF; wdata = ~v.wdata;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (ack && !got) begin
        got = 1'b1; ak = k; af = fault; ar = rdata;
      end
      if (got && !busy) break;
    end
    chk($sformatf("v%0d_ack_seen", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d_latency", idx), 32'(ak), v.flt ? 32'd0 : 32'd3);
    chk($sformatf("v%0d_busy_cycles", idx), 32'(bc), v.flt ? 32'd1 : 32'd4);
    chk($sformatf("v%0d_fault", idx), 32'(af), 32'(v.flt));
    chk($sformatf("v%0d_rdata", idx), ar, v.rd);
  endtask

  initial begin
    int rises[$];
    logic prev_busy;
    int ack_idle;

    reset_n = 1'b0; req = 1'b0; rw = 1'b0; size = 2'b00; signed_ld = 1'b0;
    addr = 32'd0; wdata = 32'd0;

    vecs.push_back(mk(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 2'b00, 1, 32'h10,  32'h0,        0, 32'hFFFFFFDE));
    vecs.push_back(mk(0, 2'b00, 0, 32'h10,  32'h0,        0, 32'h000000DE));
    vecs.push_back(mk(0, 2'b00, 1, 32'h13,  32'h0,        0, 32'hFFFFFFEF));
    vecs.push_back(mk(0, 2'b01, 0, 32'h12,  32'h0,        0, 32'h0000BEEF));
    vecs.push_back(mk(0, 2'b01, 1, 32'h12,  32'h0,        0, 32'hFFFFBEEF));
    vecs.push_back(mk(1, 2'b00, 0, 32'h11,  32'h0000005A, 0, 32'hFFFFBEEF));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        0, 32'hDE5ABEEF));
    vecs.push_back(mk(0, 2'b10, 0, 32'h11,  32'h0,        1, 32'hDE5ABEEF));
    vecs.push_back(mk(0, 2'b01, 0, 32'h13,  32'h0,        1, 32'hDE5ABEEF));
    vecs.push_back(mk(0, 2'b11, 0, 32'h10,  32'h0,        1, 32'hDE5ABEEF));
    vecs.push_back(mk(0, 2'b00, 0, 32'h100, 32'h0,        1, 32'hDE5ABEEF));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        0, 32'hDE5ABEEF));
    vecs.push_back(mk(0, 2'b00, 1, 32'h11,  32'h0,        0, 32'h0000005A));
    vecs.push_back(mk(1, 2'b10, 0, 32'h12,  32'h11111111, 1, 32'h0000005A));
    vecs.push_back(mk(0, 2'b01, 0, 32'h12,  32'h0,        0, 32'h0000BEEF));
    vecs.push_back(mk(1, 2'b00, 0, 32'hFF,  32'h00000080, 0, 32'h0000BEEF));
    vecs.push_back(mk(0, 2'b00, 1, 32'hFF,  32'h0,        0, 32'hFFFFFF80));
    vecs.push_back(mk(1, 2'b10, 0, 32'h20,  32'hCAFEF00D, 0, 32'hFFFFFF80));
    vecs.push_back(mk(0, 2'b10, 1, 32'h20,  32'h0,        0, 32'hCAFEF00D));

    repeat (2) @(negedge clk);
    chk("reset_busy",  32'(busy),  32'd0);
    chk("reset_ack",   32'(ack),   32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_rdata", rdata,      32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) txn(vecs[i], i);

    // Reset pulled between E1 and E2 of a word write; memory must keep 0xCAFEF00D.
    @(negedge clk);
    rw = 1'b1; size = 2'b10; signed_ld = 1'b0; addr = 32'h20; wdata = 32'h12345678; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy",  32'(busy), 32'd0);
    chk("midrst_ack",   32'(ack),  32'd0);
    chk("midrst_rdata", rdata,     32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    txn(mk(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'hCAFEF00D), 100);

    // Held request: one accept per IDLE visit, at edges 0, 5, 10, 15.
    @(negedge clk);
    rw = 1'b1; size = 2'b00; signed_ld = 1'b0; addr = 32'h30; wdata = 32'h01; req = 1'b1;
    prev_busy = busy;
    ack_idle = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (busy && !prev_busy) rises.push_back(e);
      if (ack && !busy) ack_idle++;
      prev_busy = busy;
    end
    req = 1'b0;
    chk("held_accept_count", 32'(rises.size()), 32'd4);
    for (int j = 0; j < 4; j++)
      chk($sformatf("held_accept_%0d", j), (j < rises.size()) ? 32'(rises[j]) : 32'hFFFFFFFF,
          32'(5 * j));
    chk("held_ack_while_idle", 32'(ack_idle), 32'd0);
    txn(mk(0, 2'b00, 0, 32'h30, 32'h0, 0, 32'h00000001), 200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d/%0d done, required completion", n_pass, n_total);
    $fatal(1);
  end

endmodule
